// File: rtl/keypad_responder_if.sv
// Request handshake between a test sequencer and the keypad model.
//   req  : one-cycle request to press `key`
//   key  : key code, row*4+col in [3:0]; bit4 set means invalid
//   busy : high while a press/release sequence is in progress
//   done : one-cycle pulse when the release phase completes
//   err  : one-cycle pulse on invalid code or scan timeout
interface keypad_responder_if;
  logic       req;
  logic [4:0] key;
  logic       busy;
  logic       done;
  logic       err;

  modport master (output req, key, input busy, done, err);
  modport slave  (input req, key, output busy, done, err);
endinterface

// File: rtl/keypad_responder.sv
// Behavioural keypad: watches the scanner's active-low row drive and answers
// on the active-low column lines as if one key were pressed, bounced, held for
// a number of row scans and then released.
//   clk, rst : clock, synchronous active-high reset
//   fila     : row drive from scanner (active-low, one row low at a time)
//   columna  : column sense back to scanner (active-low, idle 4'hF)
//   contacto : emulated contact state, 1 = closed (debug)
//   bus      : req/key in, busy/done/err out
module keypad_responder #(
  parameter int unsigned BOUNCE_CYCLES = 2000,
  parameter int unsigned BOUNCE_PERIOD = 250,
  parameter int unsigned HOLD_SCANS    = 4,
  parameter int unsigned RELEASE_SCANS = 4,
  parameter int unsigned TIMEOUT       = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          fila,
  output logic [3:0]          columna,
  output logic                contacto,
  keypad_responder_if.slave   bus
);

  localparam int unsigned SCAN_MAX = (HOLD_SCANS > RELEASE_SCANS) ? HOLD_SCANS : RELEASE_SCANS;
  localparam int BW = $clog2(BOUNCE_CYCLES) + 1;
  localparam int PW = $clog2(BOUNCE_PERIOD) + 1;
  localparam int VW = $clog2(SCAN_MAX) + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_BOUNCE, S_HOLD, S_RELEASE, S_DONE, S_ERR
  } state_t;

  state_t        state, nxt;
  logic [1:0]    tgt_row, tgt_col;
  logic          row_hit, hit_q, visit;
  logic          bph;       // bounce phase, 1 = contact closed
  logic          inv_q;     // invalid-code error pulse
  logic          contact;
  logic          done_c;
  logic          wd_exp;
  logic [BW-1:0] bcnt;
  logic [PW-1:0] pcnt;
  logic [VW-1:0] vcnt;
  logic [WW-1:0] wd;

  assign row_hit = (fila == ~(4'b0001 << tgt_row));
  assign visit   = row_hit & ~hit_q;
  // Fires on the clock that would bring the watchdog to TIMEOUT.
  assign wd_exp  = (TIMEOUT != 0) && (32'(wd) + 32'd1 >= TIMEOUT);

  // Zero-latency switch path from row drive to column sense.
  assign columna  = (contact && row_hit) ? ~(4'b0001 << tgt_col) : 4'hF;
  assign contacto = contact;

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_c;
  assign bus.err  = (state == S_ERR) | inv_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt     = state;
    contact = 1'b0;
    done_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.req && !bus.key[4])
          nxt = (BOUNCE_CYCLES == 0) ? S_HOLD : S_BOUNCE;
      end
      S_BOUNCE: begin
        contact = bph;
        if (32'(bcnt) + 32'd1 >= BOUNCE_CYCLES) nxt = S_HOLD;
      end
      S_HOLD: begin
        contact = 1'b1;
        // A visit in the same cycle as watchdog expiry takes priority.
        if (visit) begin
          if (32'(vcnt) + 32'd1 >= HOLD_SCANS) nxt = S_RELEASE;
        end else if (wd_exp) begin
          nxt = S_ERR;
        end
      end
      S_RELEASE: begin
        if (visit) begin
          if (32'(vcnt) + 32'd1 >= RELEASE_SCANS) nxt = S_DONE;
        end else if (wd_exp) begin
          nxt = S_ERR;
        end
      end
      S_DONE: begin
        done_c = 1'b1;
        nxt    = S_IDLE;
      end
      S_ERR:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_row <= '0;
      tgt_col <= '0;
      hit_q   <= 1'b0;
      bph     <= 1'b0;
      inv_q   <= 1'b0;
      bcnt    <= '0;
      pcnt    <= '0;
      vcnt    <= '0;
      wd      <= '0;
    end else begin
      hit_q <= row_hit;
      inv_q <= (state == S_IDLE) && bus.req && bus.key[4];
      if (state == S_IDLE && bus.req && !bus.key[4]) begin
        tgt_row <= bus.key[3:2];
        tgt_col <= bus.key[1:0];
        bph     <= 1'b1;
      end
      if (nxt != state) begin
        // Every state entry starts its counters from zero.
        bcnt <= '0;
        pcnt <= '0;
        vcnt <= '0;
        wd   <= '0;
      end else begin
        if (state == S_BOUNCE) begin
          if (~&bcnt) bcnt <= bcnt + 1'b1;
          if (32'(pcnt) + 32'd1 >= BOUNCE_PERIOD) begin
            pcnt <= '0;
            bph  <= ~bph;
          end else if (~&pcnt) begin
            pcnt <= pcnt + 1'b1;
          end
        end
        if (state == S_HOLD || state == S_RELEASE) begin
          if (visit) begin
            if (~&vcnt) vcnt <= vcnt + 1'b1;
            wd <= '0;
          end else if (~&wd) begin
            wd <= wd + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_responder.sv
module tb_keypad_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fila_a = 4'b1110;
  logic [3:0] fila_b = 4'b1111;
  logic [3:0] columna_a, columna_b;
  logic       contacto_a, contacto_b;

  int checks   = 0;
  int failures = 0;

  keypad_responder_if if_a();
  keypad_responder_if if_b();

  always #5 clk = ~clk;

  keypad_responder #(
    .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(1), .HOLD_SCANS(4),
    .RELEASE_SCANS(4), .TIMEOUT(500)
  ) dut_a (
    .clk(clk), .rst(rst), .fila(fila_a), .columna(columna_a),
    .contacto(contacto_a), .bus(if_a)
  );

  keypad_responder #(
    .BOUNCE_CYCLES(1000), .BOUNCE_PERIOD(100), .HOLD_SCANS(4),
    .RELEASE_SCANS(4), .TIMEOUT(0)
  ) dut_b (
    .clk(clk), .rst(rst), .fila(fila_b), .columna(columna_b),
    .contacto(contacto_b), .bus(if_b)
  );

  typedef struct {
    logic [3:0] fila;
    logic       req;
    logic [4:0] key;
    logic [3:0] col;
    logic       busy;
    logic       done;
    logic       err;
    logic       cont;
  } vec_t;

  typedef struct {
    int   idx;
    vec_t v;
  } sb_t;

  sb_t sb[$];

  function automatic vec_t mk(input logic [3:0] f, input logic r, input logic [4:0] k,
                              input logic [3:0] c, input logic b, input logic d,
                              input logic e, input logic ct);
    vec_t v;
    v.fila = f; v.req = r; v.key = k; v.col = c;
    v.busy = b; v.done = d; v.err = e; v.cont = ct;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: expectations are pushed as vectors are driven.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_t e;
      e = sb.pop_front();
      checks++;
      if (columna_a !== e.v.col || if_a.busy !== e.v.busy || if_a.done !== e.v.done ||
          if_a.err !== e.v.err || contacto_a !== e.v.cont) begin
        failures++;
        $display("FAIL vec%0d: got col=%b busy=%b done=%b err=%b cont=%b expected col=%b busy=%b done=%b err=%b cont=%b",
                 e.idx, columna_a, if_a.busy, if_a.done, if_a.err, contacto_a,
                 e.v.col, e.v.busy, e.v.done, e.v.err, e.v.cont);
      end
    end
  end

  // Rotating scan on dut_a; press must already be requested.
  task automatic rotate(input int per, input logic [3:0] hf, input logic [3:0] hc, input string tag);
    int wins = 0, dones = 0, errs = 0, bad = 0, busybad = 0;
    logic [3:0] prev = 4'hF;
    logic pd = 1'b0;
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < per; c++) begin
        step();
        fila_a = ~(4'b0001 << (r % 4));
        @(negedge clk);
        if (columna_a != 4'hF && !(fila_a == hf && columna_a == hc)) bad++;
        if (columna_a == hc && prev != hc) wins++;
        if (if_a.done) begin
          dones++;
          if (!if_a.busy) busybad++;
        end
        if (pd && if_a.busy) busybad++;
        if (if_a.err) errs++;
        prev = columna_a;
        pd = if_a.done;
      end
    end
    chk({tag, "_windows"}, wins, 4);
    chk({tag, "_col_off_row"}, bad, 0);
    chk({tag, "_done_pulses"}, dones, 1);
    chk({tag, "_busy_edge"}, busybad, 0);
    chk({tag, "_err"}, errs, 0);
    chk({tag, "_idle_busy"}, if_a.busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t tbl[25];
    int first, dn, mism;
    logic c0, cont_at, busy_at, busy_nx;
    logic [3:0] exp;

    tbl[0]  = mk(4'b1110, 1, 5'd6,  4'hF,    0, 0, 0, 0);
    tbl[1]  = mk(4'b1110, 0, 5'd0,  4'hF,    1, 0, 0, 1);
    tbl[2]  = mk(4'b1101, 0, 5'd0,  4'b1011, 1, 0, 0, 1);
    tbl[3]  = mk(4'b1101, 0, 5'd0,  4'b1011, 1, 0, 0, 1);
    tbl[4]  = mk(4'b1111, 0, 5'd0,  4'hF,    1, 0, 0, 1);
    tbl[5]  = mk(4'b1001, 0, 5'd0,  4'hF,    1, 0, 0, 1);
    tbl[6]  = mk(4'b1101, 0, 5'd0,  4'b1011, 1, 0, 0, 1);
    tbl[7]  = mk(4'b0111, 1, 5'd15, 4'hF,    1, 0, 0, 1);
    tbl[8]  = mk(4'b1101, 0, 5'd0,  4'b1011, 1, 0, 0, 1);
    tbl[9]  = mk(4'b1011, 0, 5'd0,  4'hF,    1, 0, 0, 1);
    tbl[10] = mk(4'b1101, 0, 5'd0,  4'b1011, 1, 0, 0, 1);
    tbl[11] = mk(4'b1101, 0, 5'd0,  4'hF,    1, 0, 0, 0);
    tbl[12] = mk(4'b1110, 0, 5'd0,  4'hF,    1, 0, 0, 0);
    tbl[13] = mk(4'b1101, 0, 5'd0,  4'hF,    1, 0, 0, 0);
    tbl[14] = mk(4'b1110, 0, 5'd0,  4'hF,    1, 0, 0, 0);
    tbl[15] = mk(4'b1101, 0, 5'd0,  4'hF,    1, 0, 0, 0);
    tbl[16] = mk(4'b1110, 0, 5'd0,  4'hF,    1, 0, 0, 0);
    tbl[17] = mk(4'b1101, 0, 5'd0,  4'hF,    1, 0, 0, 0);
    tbl[18] = mk(4'b1110, 0, 5'd0,  4'hF,    1, 0, 0, 0);
    tbl[19] = mk(4'b1101, 0, 5'd0,  4'hF,    1, 0, 0, 0);
    tbl[20] = mk(4'b1110, 0, 5'd0,  4'hF,    1, 1, 0, 0);
    tbl[21] = mk(4'b1110, 0, 5'd0,  4'hF,    0, 0, 0, 0);
    tbl[22] = mk(4'b1110, 1, 5'd16, 4'hF,    0, 0, 0, 0);
    tbl[23] = mk(4'b1110, 0, 5'd0,  4'hF,    0, 0, 1, 0);
    tbl[24] = mk(4'b1110, 0, 5'd0,  4'hF,    0, 0, 0, 0);

    if_a.req = 0; if_a.key = 0;
    if_b.req = 0; if_b.key = 0;

    // Reset
    rst = 1; fila_a = 4'b1110;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_columna", columna_a, 4'hF);
    chk("rst_busy", if_a.busy, 0);
    chk("rst_done", if_a.done, 0);
    chk("rst_err", if_a.err, 0);
    chk("rst_contacto", contacto_a, 0);
    rst = 0;

    // Table: decode, hold/release visit counting, ignored and invalid requests
    for (int i = 0; i < 25; i++) begin
      sb_t s;
      step();
      fila_a = tbl[i].fila; if_a.req = tbl[i].req; if_a.key = tbl[i].key;
      s.idx = i; s.v = tbl[i];
      sb.push_back(s);
    end
    step();
    if_a.req = 0;

    // Basic press with a rotating scan
    fila_a = 4'b1110; if_a.req = 1; if_a.key = 5'd6;
    step();
    if_a.req = 0;
    rotate(100, 4'b1101, 4'b1011, "basic");

    // Timeout with the row drive stuck high
    step();
    fila_a = 4'hF; if_a.req = 1; if_a.key = 5'd0;
    step();
    if_a.req = 0;
    first = -1; dn = 0; c0 = 0; cont_at = 1; busy_at = 0; busy_nx = 1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (n == 0) c0 = contacto_a;
      if (first >= 0 && n == first + 1) busy_nx = if_a.busy;
      if (if_a.err && first < 0) begin
        first = n; cont_at = contacto_a; busy_at = if_a.busy;
      end
      if (if_a.done) dn++;
      step();
    end
    chk("to_contact_start", c0, 1);
    chk("to_err_cycle", first, 500);
    chk("to_contact_open", cont_at, 0);
    chk("to_busy_at_err", busy_at, 1);
    chk("to_busy_after", busy_nx, 0);
    chk("to_no_done", dn, 0);

    // Reset in the middle of HOLD, then a fresh press on key 15
    fila_a = 4'b1110; if_a.req = 1; if_a.key = 5'd6;
    step();
    if_a.req = 0;
    step(); fila_a = 4'b1101;
    step(); fila_a = 4'b1110;
    step(); fila_a = 4'b1101;
    @(negedge clk);
    chk("mid_hold_col", columna_a, 4'b1011);
    step(); rst = 1;
    step();
    chk("mid_rst_col", columna_a, 4'hF);
    chk("mid_rst_busy", if_a.busy, 0);
    chk("mid_rst_err", if_a.err, 0);
    chk("mid_rst_done", if_a.done, 0);
    rst = 0;
    step();
    fila_a = 4'b1110; if_a.req = 1; if_a.key = 5'd15;
    step();
    if_a.req = 0;
    rotate(20, 4'b0111, 4'b0111, "k15");

    // Bounce on the second instance
    step();
    fila_b = 4'b1110; if_b.req = 1; if_b.key = 5'd0;
    step();
    if_b.req = 0;
    mism = 0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      exp = (k >= 1000 || ((k / 100) % 2 == 0)) ? 4'b1110 : 4'b1111;
      if (columna_b !== exp) mism++;
      if (k == 0 || k == 99 || k == 100 || k == 999 || k == 1000)
        chk($sformatf("bounce_k%0d", k), columna_b, exp);
      step();
    end
    chk("bounce_mismatches", mism, 0);
    chk("bounce_busy", if_b.busy, 1);
    chk("bounce_contacto", contacto_b, 1);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
